// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debounce logic.
//   debounce_state_t : two-state qualification FSM encoding
//   GLITCH_W / GLITCH_MAX : width and saturation value of the abort counter
//   cnt_width()       : width of a counter that must hold 0..cycles
package debounce_pkg;

    typedef enum logic {
        STABLE = 1'b0,
        SETTLE = 1'b1
    } debounce_state_t;

    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Signal bundle between a raw push-button source and its debouncer.
//   button_in    : raw asynchronous button level (source -> debouncer)
//   glitch_clr   : synchronous clear of glitch_count (source -> debouncer)
//   button_out   : debounced level (debouncer -> source)
//   changed      : one-cycle strobe on every button_out toggle
//   glitch_count : saturating count of aborted settle attempts
// master = the side driving the raw button, slave = the debouncer.
interface button_debounce_if;
    import debounce_pkg::*;

    logic                button_in;
    logic                glitch_clr;
    logic                button_out;
    logic                changed;
    logic [GLITCH_W-1:0] glitch_count;

    modport master (
        output button_in,
        output glitch_clr,
        input  button_out,
        input  changed,
        input  glitch_count
    );

    modport slave (
        input  button_in,
        input  glitch_clr,
        output button_out,
        output changed,
        output glitch_count
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk         : destination clock
//   reset_n     : asynchronous active-low reset, loads RESET_VALUE into every stage
//   d           : asynchronous input
//   q           : synchronized output (last stage)
// The chain is a pure shift register: no logic between stages so every
// flop gets a full period to resolve metastability.
module bit_synchronizer #(
    parameter int   DEPTH       = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= {DEPTH{RESET_VALUE}};
        end else begin
            sync_reg <= {sync_reg[DEPTH-2:0], d};
        end
    end

    assign q = sync_reg[DEPTH-1];

endmodule

// File: rtl/button_debounce.sv
// Synchronizes and debounces one mechanical push-button into a clean level.
//   clk          : system clock
//   reset_qual_n : asynchronous active-low reset
//   bus.button_in, bus.glitch_clr            : inputs (slave modport)
//   bus.button_out, bus.changed, bus.glitch_count : registered outputs
// A new level is accepted only after DEBOUNCE_CYCLES consecutive synchronized
// samples disagree with the current output; any agreeing sample in between
// aborts the attempt and bumps the saturating glitch counter.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic             clk,
    input  logic             reset_qual_n,
    button_debounce_if.slave bus
);

    localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic sync_in;

    debounce_state_t     state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                level_reg, level_next;
    logic                changed_reg, changed_next;
    logic [GLITCH_W-1:0] glitch_reg, glitch_next;
    logic                settle_abort;

    bit_synchronizer #(
        .DEPTH      (SYNC_STAGES),
        .RESET_VALUE(RESET_LEVEL)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_qual_n),
        .d      (bus.button_in),
        .q      (sync_in)
    );

    always_ff @(posedge clk or negedge reset_qual_n) begin
        if (!reset_qual_n) begin
            state_reg   <= STABLE;
            cnt_reg     <= '0;
            level_reg   <= RESET_LEVEL;
            changed_reg <= 1'b0;
            glitch_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            level_reg   <= level_next;
            changed_reg <= changed_next;
            glitch_reg  <= glitch_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        level_next   = level_reg;
        changed_next = 1'b0;
        settle_abort = 1'b0;

        case (state_reg)
            STABLE: begin
                // The first disagreeing sample already counts as one stable sample.
                if (sync_in != level_reg) begin
                    state_next = SETTLE;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = '0;
                end
            end
            SETTLE: begin
                if (sync_in == level_reg) begin
                    state_next   = STABLE;
                    cnt_next     = '0;
                    settle_abort = 1'b1;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = STABLE;
                    cnt_next     = '0;
                    level_next   = ~level_reg;
                    changed_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase

        // Clear has priority over a coincident abort.
        glitch_next = glitch_reg;
        if (bus.glitch_clr) begin
            glitch_next = '0;
        end else if (settle_abort && (glitch_reg != GLITCH_MAX)) begin
            glitch_next = glitch_reg + GLITCH_W'(1);
        end
    end

    assign bus.button_out   = level_reg;
    assign bus.changed      = changed_reg;
    assign bus.glitch_count = glitch_reg;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    localparam int   SS = 2;
    localparam int   DC = 8;
    localparam logic RL = 1'b1;

    logic clk = 1'b0;
    logic reset_qual_n = 1'b0;
    always #5 clk = ~clk;

    button_debounce_if bus();

    button_debounce #(
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (RL)
    ) dut (
        .clk         (clk),
        .reset_qual_n(reset_qual_n),
        .bus         (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the raw input is delayed SS edges, then a new level is
    // accepted after DC consecutive disagreeing samples; an agreeing sample
    // after at least one disagreeing one is an abort.
    logic m_hist[SS];
    logic m_level;
    logic m_changed;
    int   m_run;
    int   m_glitch;

    always @(posedge clk or negedge reset_qual_n) begin
        logic s;
        bit   abort;
        if (!reset_qual_n) begin
            for (int i = 0; i < SS; i++) m_hist[i] = RL;
            m_level   = RL;
            m_changed = 1'b0;
            m_run     = 0;
            m_glitch  = 0;
        end else begin
            s = m_hist[SS-1];
            for (int i = SS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = bus.button_in;
            m_changed = 1'b0;
            abort     = 1'b0;
            if (s != m_level) begin
                m_run++;
                if (m_run == DC) begin
                    m_level   = ~m_level;
                    m_changed = 1'b1;
                    m_run     = 0;
                end
            end else begin
                abort = (m_run > 0);
                m_run = 0;
            end
            if (bus.glitch_clr) m_glitch = 0;
            else if (abort && m_glitch < 255) m_glitch++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.button_in  = RL;
        bus.glitch_clr = 1'b0;
        reset_qual_n   = 1'b0;
        repeat (3) tick();
        reset_qual_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (bus.button_out !== 1'b1) begin
                errors++; $display("FAIL reset_out n=%0d: got %0b expected 1", n, bus.button_out);
            end
            checks++;
            if (bus.changed !== 1'b0) begin
                errors++; $display("FAIL reset_changed n=%0d: got %0b expected 0", n, bus.changed);
            end
            checks++;
            if (bus.glitch_count !== 8'd0) begin
                errors++; $display("FAIL reset_glitch n=%0d: got %0d expected 0", n, bus.glitch_count);
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_latency();
        logic exp_out;
        logic exp_chg;
        bus.button_in = 1'b0;
        for (int n = 0; n < 13; n++) begin
            tick();
            exp_out = (n >= SS + DC - 1) ? 1'b0 : 1'b1;
            exp_chg = (n == SS + DC - 1);
            checks++;
            if (bus.button_out !== exp_out) begin
                errors++; $display("FAIL latency_out edge=%0d: got %0b expected %0b", n, bus.button_out, exp_out);
            end
            checks++;
            if (bus.changed !== exp_chg) begin
                errors++; $display("FAIL latency_changed edge=%0d: got %0b expected %0b", n, bus.changed, exp_chg);
            end
        end
        bus.button_in = 1'b1;
        for (int n = 0; n < 13; n++) begin
            tick();
            exp_out = (n >= SS + DC - 1) ? 1'b1 : 1'b0;
            checks++;
            if (bus.button_out !== exp_out) begin
                errors++; $display("FAIL latency_rise edge=%0d: got %0b expected %0b", n, bus.button_out, exp_out);
            end
        end
        $display("test_latency done");
    endtask

    task automatic test_bounce();
        logic exp_out;
        logic exp_chg;
        logic [7:0] exp_gc;
        for (int k = 0; k < 20; k++) begin
            bus.button_in = (k < 3) ? 1'b0 : (k < 5) ? 1'b1 : 1'b0;
            tick();
            exp_out = (k >= 14) ? 1'b0 : 1'b1;
            exp_chg = (k == 14);
            exp_gc  = (k >= 5) ? 8'd1 : 8'd0;
            checks++;
            if (bus.button_out !== exp_out) begin
                errors++; $display("FAIL bounce_out k=%0d: got %0b expected %0b", k, bus.button_out, exp_out);
            end
            checks++;
            if (bus.changed !== exp_chg) begin
                errors++; $display("FAIL bounce_changed k=%0d: got %0b expected %0b", k, bus.changed, exp_chg);
            end
            checks++;
            if (bus.glitch_count !== exp_gc) begin
                errors++; $display("FAIL bounce_glitch k=%0d: got %0d expected %0d", k, bus.glitch_count, exp_gc);
            end
        end
        bus.button_in = 1'b1;
        repeat (12) tick();
        $display("test_bounce done");
    endtask

    task automatic test_saturate();
        for (int a = 0; a < 300; a++) begin
            for (int h = 0; h < 2; h++) begin
                bus.button_in = (h == 0) ? 1'b0 : 1'b1;
                tick();
                checks++;
                if (bus.glitch_count !== 8'(m_glitch) || bus.button_out !== m_level) begin
                    errors++;
                    $display("FAIL saturate_track a=%0d: got gc=%0d out=%0b expected gc=%0d out=%0b",
                             a, bus.glitch_count, bus.button_out, m_glitch, m_level);
                end
            end
        end
        repeat (3) tick();
        checks++;
        if (bus.glitch_count !== 8'd255) begin
            errors++; $display("FAIL saturate_max: got %0d expected 255", bus.glitch_count);
        end
        // Abort lands on the fourth edge of the pulse; clear on that same edge.
        bus.button_in = 1'b0; tick();
        bus.button_in = 1'b1; tick();
        tick();
        bus.glitch_clr = 1'b1; tick();
        bus.glitch_clr = 1'b0;
        checks++;
        if (bus.glitch_count !== 8'd0) begin
            errors++; $display("FAIL clear_on_abort: got %0d expected 0", bus.glitch_count);
        end
        bus.button_in = 1'b0; tick();
        bus.button_in = 1'b1; tick();
        tick();
        tick();
        checks++;
        if (bus.glitch_count !== 8'd1) begin
            errors++; $display("FAIL count_after_clear: got %0d expected 1", bus.glitch_count);
        end
        $display("test_saturate done");
    endtask

    task automatic test_reset_mid_settle();
        bus.button_in = 1'b0;
        for (int n = 0; n < 7; n++) tick();
        // Seven edges in: the FSM has seen five disagreeing samples.
        reset_qual_n = 1'b0;
        #1;
        checks++;
        if (bus.button_out !== RL || bus.changed !== 1'b0 || bus.glitch_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_mid_settle: got out=%0b chg=%0b gc=%0d expected out=1 chg=0 gc=0",
                     bus.button_out, bus.changed, bus.glitch_count);
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (bus.button_out !== RL || bus.changed !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold n=%0d: got out=%0b chg=%0b expected out=1 chg=0",
                         n, bus.button_out, bus.changed);
            end
        end
        $display("test_reset_mid_settle done");
    endtask

    task automatic test_reset_release_low();
        logic exp_out;
        logic exp_chg;
        int   strobes;
        strobes = 0;
        reset_qual_n = 1'b1;
        for (int n = 0; n < 14; n++) begin
            tick();
            exp_out = (n >= SS + DC - 1) ? 1'b0 : 1'b1;
            exp_chg = (n == SS + DC - 1);
            if (bus.changed === 1'b1) strobes++;
            checks++;
            if (bus.button_out !== exp_out) begin
                errors++; $display("FAIL release_out edge=%0d: got %0b expected %0b", n, bus.button_out, exp_out);
            end
            checks++;
            if (bus.changed !== exp_chg) begin
                errors++; $display("FAIL release_changed edge=%0d: got %0b expected %0b", n, bus.changed, exp_chg);
            end
        end
        checks++;
        if (strobes != 1) begin
            errors++; $display("FAIL release_strobes: got %0d expected 1", strobes);
        end
        $display("test_reset_release_low done");
    endtask

    task automatic test_random();
        int   hold;
        logic lvl;
        int   cyc;
        cyc = 0;
        while (cyc < 1500) begin
            lvl  = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 12);
            for (int h = 0; h < hold; h++) begin
                bus.button_in  = lvl;
                bus.glitch_clr = ($urandom_range(0, 15) == 0);
                tick();
                cyc++;
                checks++;
                if (bus.button_out !== m_level) begin
                    errors++; $display("FAIL random_out cyc=%0d: got %0b expected %0b", cyc, bus.button_out, m_level);
                end
                checks++;
                if (bus.changed !== m_changed) begin
                    errors++; $display("FAIL random_changed cyc=%0d: got %0b expected %0b", cyc, bus.changed, m_changed);
                end
                checks++;
                if (bus.glitch_count !== 8'(m_glitch)) begin
                    errors++; $display("FAIL random_glitch cyc=%0d: got %0d expected %0d", cyc, bus.glitch_count, m_glitch);
                end
            end
        end
        bus.glitch_clr = 1'b0;
        $display("test_random done: %0d cycles", cyc);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_bounce();
        test_saturate();
        test_reset_mid_settle();
        test_reset_release_low();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
